// File: rtl/adc_pkt_pkg.sv
// Shared definitions for the ADC capture stream framing, used by both transmit and receive sides.
package adc_pkt_pkg;

  localparam int          LANES           = 24;
  localparam int          WORD_W          = 18;
  localparam int          WORDS_PER_FRAME = 2 * LANES;
  localparam int          SEQ_W           = 8;
  localparam logic [9:0]  HDR_MARK        = 10'h2A5;

  // Header word layout: marker in the upper field, sequence number in the low byte.
  localparam int HDR_MARK_HI = 17;
  localparam int HDR_MARK_LO = 8;
  localparam int HDR_SEQ_HI  = 7;
  localparam int HDR_SEQ_LO  = 0;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

endpackage

// File: rtl/adc_pkt_unpack.sv
// Receive-side depacketizer: hunts for the frame header, reassembles 2*LANES stream words
// into LANES parallel lane samples, and flags sequence and framing (gap timeout) errors.
module adc_pkt_unpack
  import adc_pkt_pkg::*;
#(
  parameter int         LANES    = adc_pkt_pkg::LANES,
  parameter int         WORD_W   = adc_pkt_pkg::WORD_W,
  parameter int         GAP_MAX  = 15,
  parameter logic [9:0] HDR_MARK = adc_pkt_pkg::HDR_MARK
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WORD_W-1:0]           ADC_DATA,
  input  logic                        ADC_DATA_VALID,
  output logic [LANES*2*WORD_W-1:0]   frame_data,
  output logic                        frame_valid,
  output logic [SEQ_W-1:0]            frame_seq,
  output logic                        seq_err,
  output logic                        frame_err,
  output logic                        locked,
  output logic                        dbg_state_o
);

  // Stream handshake: a word transfers on every rising edge where ADC_DATA_VALID is high;
  // there is no ready/backpressure, so the unpacker must accept one word per cycle.

  localparam int WORDS   = 2 * LANES;
  localparam int CNT_W   = $clog2(WORDS);
  localparam int GAP_W   = (GAP_MAX < 1) ? 1 : $clog2(GAP_MAX + 1);
  localparam int FRAME_W = WORDS * WORD_W;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [SEQ_W-1:0]    hdr_seq_q, hdr_seq_d;
  logic [WORD_W-1:0]   stage_q [WORDS];
  logic [FRAME_W-1:0]  frame_data_q, frame_next;
  logic [SEQ_W-1:0]    frame_seq_q;
  logic                frame_valid_q, seq_err_q, frame_err_q, locked_q;

  logic stage_we, deliver, abort, hdr_hit, seq_mismatch;

  assign hdr_hit      = (ADC_DATA[HDR_MARK_HI:HDR_MARK_LO] == HDR_MARK);
  assign seq_mismatch = locked_q && (hdr_seq_q != (frame_seq_q + SEQ_W'(1)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gap_d     = gap_q;
    hdr_seq_d = hdr_seq_q;
    stage_we  = 1'b0;
    deliver   = 1'b0;
    abort     = 1'b0;
    case (state_q)
      HUNT: begin
        if (ADC_DATA_VALID && hdr_hit) begin
          hdr_seq_d = ADC_DATA[HDR_SEQ_HI:HDR_SEQ_LO];
          cnt_d     = '0;
          gap_d     = '0;
          state_d   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // Header-pattern words are plain data here; no mid-frame resync.
        if (ADC_DATA_VALID) begin
          stage_we = 1'b1;
          gap_d    = '0;
          if (cnt_q == CNT_W'(WORDS - 1)) begin
            deliver = 1'b1;
            cnt_d   = '0;
            state_d = HUNT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (gap_q == GAP_W'(GAP_MAX)) begin
          abort   = 1'b1;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = HUNT;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  // The final payload word is taken straight from the input so the frame lands on the same edge.
  always_comb begin
    frame_next = '0;
    for (int w = 0; w < WORDS; w++) begin
      frame_next[w*WORD_W +: WORD_W] = stage_q[w];
    end
    frame_next[(WORDS-1)*WORD_W +: WORD_W] = ADC_DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      cnt_q     <= '0;
      gap_q     <= '0;
      hdr_seq_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      hdr_seq_q <= hdr_seq_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        stage_q[i] <= '0;
      end
    end else if (stage_we) begin
      for (int i = 0; i < WORDS; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          stage_q[i] <= ADC_DATA;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data_q  <= '0;
      frame_seq_q   <= '0;
      frame_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      frame_valid_q <= deliver;
      seq_err_q     <= deliver && seq_mismatch;
      frame_err_q   <= abort;
      if (deliver) begin
        frame_data_q <= frame_next;
        frame_seq_q  <= hdr_seq_q;
        locked_q     <= !seq_mismatch;
      end else if (abort) begin
        locked_q <= 1'b0;
      end
    end
  end

  assign frame_data  = frame_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_seq   = frame_seq_q;
  assign seq_err     = seq_err_q;
  assign frame_err   = frame_err_q;
  assign locked      = locked_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_pkt_unpack.sv
// Randomized scoreboard bench for adc_pkt_unpack: frame-level reference model feeds an
// expected-event queue; a negedge monitor pops and compares on every output pulse.
module tb_adc_pkt_unpack;

  localparam int L  = 24;
  localparam int W  = 18;
  localparam int NW = 2 * L;
  localparam int FW = NW * W;
  localparam logic [9:0] MARK = 10'h2A5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  adc_data;
  logic          adc_valid;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic [7:0]    frame_seq;
  logic          seq_err;
  logic          frame_err;
  logic          locked;
  logic          dbg_state;

  adc_pkt_unpack dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ADC_DATA       (adc_data),
    .ADC_DATA_VALID (adc_valid),
    .frame_data     (frame_data),
    .frame_valid    (frame_valid),
    .frame_seq      (frame_seq),
    .seq_err        (seq_err),
    .frame_err      (frame_err),
    .locked         (locked),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    bit          is_err;
    logic [FW-1:0] data;
    logic [7:0]  seq;
    bit          serr;
    bit          lck;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: what a receiver should remember between frames.
  bit            m_locked;
  logic [7:0]    m_last_seq;
  logic [FW-1:0] m_last_data;
  logic [W-1:0]  fw [NW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      for (int k = 0; k < L; k++) begin
        if (act[k*2*W +: 2*W] !== exp[k*2*W +: 2*W]) begin
          $display("FAIL %s: lane %0d got %0h expected %0h (t=%0t)", name, k,
                   act[k*2*W +: 2*W], exp[k*2*W +: 2*W], $time);
          break;
        end
      end
    end
  endtask

  function automatic logic [FW-1:0] pack_frame();
    logic [FW-1:0] d;
    for (int i = 0; i < NW; i++) d[i*W +: W] = fw[i];
    return d;
  endfunction

  function automatic logic [W-1:0] rand_garbage();
    logic [W-1:0] w;
    do w = W'($urandom); while (w[17:8] == MARK);
    return w;
  endfunction

  task automatic model_reset();
    m_locked    = 1'b0;
    m_last_seq  = '0;
    m_last_data = '0;
  endtask

  task automatic push_delivery(input logic [7:0] seq, input int at_cyc);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = pack_frame();
    e.seq    = seq;
    e.serr   = m_locked && (seq != 8'(m_last_seq + 8'd1));
    e.lck    = !e.serr;
    e.cyc    = at_cyc;
    m_locked    = e.lck;
    m_last_seq  = seq;
    m_last_data = e.data;
    exp_q.push_back(e);
  endtask

  task automatic push_abort(input int at_cyc);
    exp_t e;
    e.is_err = 1'b1;
    e.data   = m_last_data;
    e.seq    = m_last_seq;
    e.serr   = 1'b0;
    e.lck    = 1'b0;
    e.cyc    = at_cyc;
    m_locked = 1'b0;
    exp_q.push_back(e);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [W-1:0] d);
    adc_valid = v;
    adc_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Sends header + payload from fw[]; a gap of gap_len invalid cycles is inserted before
  // payload word gap_pos. A gap of 16 or more abandons the rest of the frame.
  task automatic send_frame(input logic [7:0] seq, input int n_garbage,
                            input int gap_pos, input int gap_len, input int idle_after);
    for (int g = 0; g < n_garbage; g++) drive(1'b1, rand_garbage());
    drive(1'b1, {MARK, seq});
    for (int i = 0; i < NW; i++) begin
      if (i == gap_pos) begin
        for (int j = 0; j < gap_len; j++) begin
          drive(1'b0, W'($urandom));
          if (j == 15) push_abort(cyc);
        end
        if (gap_len >= 16) return;
      end
      drive(1'b1, fw[i]);
    end
    push_delivery(seq, cyc);
    for (int k = 0; k < idle_after; k++) drive(1'b0, W'($urandom));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    drive(1'b0, '0);
    drive(1'b0, '0);
    rst_n = 1'b1;
    drive(1'b0, '0);
  endtask

  task automatic fill_random(input int hdr_pct);
    for (int i = 0; i < NW; i++) begin
      if ($urandom_range(99, 0) < hdr_pct) fw[i] = {MARK, 8'($urandom)};
      else fw[i] = W'($urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_data_lo"}, frame_data[63:0], 64'd0);
    check({tag, "_frame_data_hi"}, frame_data[FW-1 -: 64], 64'd0);
    check({tag, "_frame_seq"}, frame_seq, 64'd0);
    check({tag, "_frame_valid"}, frame_valid, 64'd0);
    check({tag, "_seq_err"}, seq_err, 64'd0);
    check({tag, "_frame_err"}, frame_err, 64'd0);
    check({tag, "_locked"}, locked, 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected no pulse (t=%0t)",
                   frame_valid, frame_err, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_is_err", frame_err, e.is_err);
          check("pulse_is_valid", frame_valid, !e.is_err);
          check("pulse_cycle", cyc, e.cyc);
          check_frame("frame_data", frame_data, e.data);
          check("frame_seq", frame_seq, e.seq);
          check("seq_err", seq_err, e.serr);
          check("locked", locked, e.lck);
        end
      end else if (seq_err) begin
        n_checks++;
        n_fail++;
        $display("FAIL seq_err_alone: got 1 expected 0 (t=%0t)", $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    adc_valid = 1'b0;
    adc_data  = '0;
    model_reset();
    drive(1'b0, '0);
    drive(1'b0, '0);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    drive(1'b0, '0);

    // Counting frame with seq 0
    for (int i = 0; i < NW; i++) fw[i] = W'(i);
    send_frame(8'h00, 0, -1, 0, 1);
    check("lane0", frame_data[35:0], {18'd1, 18'd0});
    check("lane23", frame_data[FW-1 -: 36], {18'd47, 18'd46});

    // Back-to-back seq 5, 6, 8 from an unlocked start
    apply_reset();
    fill_random(0);
    send_frame(8'd5, 0, -1, 0, 0);
    fill_random(0);
    send_frame(8'd6, 0, -1, 0, 0);
    fill_random(0);
    send_frame(8'd8, 0, -1, 0, 2);

    // Gap of 15 completes, gap of 16 aborts
    fill_random(0);
    send_frame(8'd9, 0, 10, 15, 2);
    fill_random(0);
    send_frame(8'd10, 0, 10, 16, 3);
    fill_random(0);
    send_frame(8'd11, 0, 0, 16, 3);

    // Garbage before header, header pattern inside payload
    for (int g = 0; g < 5; g++) drive(1'b1, 18'h3FFFF);
    fill_random(0);
    fw[17] = 18'h2A53C;
    send_frame(8'd12, 0, -1, 0, 1);
    check("hdr_as_data_lane8", frame_data[8*36+18 +: 18], 18'h2A53C);

    // Reset at payload word 30
    fill_random(0);
    drive(1'b1, {MARK, 8'd13});
    for (int i = 0; i < 30; i++) drive(1'b1, fw[i]);
    rst_n = 1'b0;
    model_reset();
    drive(1'b1, fw[30]);
    drive(1'b0, '0);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    drive(1'b0, '0);
    fill_random(0);
    send_frame(8'd77, 0, -1, 0, 1);

    // Randomized traffic
    for (int f = 0; f < 40; f++) begin
      logic [7:0] s;
      int gp, gl;
      s = ($urandom_range(99, 0) < 70) ? 8'(m_last_seq + 8'd1) : 8'($urandom);
      gp = -1;
      gl = 0;
      if ($urandom_range(99, 0) < 25) begin
        gp = $urandom_range(NW - 1, 0);
        gl = $urandom_range(20, 1);
      end
      fill_random(10);
      send_frame(s, $urandom_range(3, 0), gp, gl, $urandom_range(2, 0));
    end

    repeat (5) drive(1'b0, '0);
    check("exp_queue_empty", exp_q.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
